door_code_tx: RTL and testbench

- Serial code transmitter that drives the door-lock FSM's 1-bit code input. It is the sending end of the lock's serial code interface.
- On a start request it latches a parallel code and shifts it out MSB first, one bit per clock. It then watches the lock's unlock feedback for a bounded window.
- If no unlock arrives it retransmits, up to a retry limit, then reports done or fail.
- Sits between keypad/host logic and the door-lock FSM.

---
 rtl/door_code_tx.sv | 168 ++++++++++++++++
 tb/tb_door_code_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/door_code_tx.sv
// door_code_tx: serial code transmitter feeding the door-lock FSM code input.
// Build option PARITY_TX_EN appends an even-parity bit to every attempt.
module door_code_tx #(
    parameter int CODE_W     = 4,
    parameter int GAP_CYCLES = 3,
    parameter int MAX_RETRY  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    input  logic              abort,
    input  logic              unlocked_in,
    output logic              code_out,
    output logic              busy,
    output logic              done,
    output logic              fail
);

`ifdef PARITY_TX_EN
    localparam int NB = CODE_W + 1;
`else
    localparam int NB = CODE_W;
`endif

    localparam int BW = $clog2(NB);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [BW-1:0] BIT_LAST  = BW'(NB - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_FAIL = 3'd4;

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] code_q_nx;
    logic [NB-1:0]     shreg;
    logic [NB-1:0]     shreg_nx;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     bit_cnt_nx;
    logic [GW-1:0]     gap_cnt;
    logic [GW-1:0]     gap_cnt_nx;
    logic [RW-1:0]     retry_cnt;
    logic [RW-1:0]     retry_cnt_nx;
    logic              code_out_nx;
    logic              busy_nx;
    logic              done_nx;
    logic              fail_nx;

    logic [NB-1:0]     new_frame;
    logic [NB-1:0]     old_frame;

    function automatic logic [NB-1:0] frame(input logic [CODE_W-1:0] c);
`ifdef PARITY_TX_EN
        return {c, ^c};
`else
        return c;
`endif
    endfunction

    assign new_frame = frame(code);
    assign old_frame = frame(code_q);

    // shreg holds the bits still to go; code_out already carries the current one
    always_comb begin
        state_nx     = state;
        code_q_nx    = code_q;
        shreg_nx     = shreg;
        bit_cnt_nx   = bit_cnt;
        gap_cnt_nx   = gap_cnt;
        retry_cnt_nx = retry_cnt;
        code_out_nx  = 1'b0;
        done_nx      = 1'b0;
        fail_nx      = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    code_q_nx    = code;
                    shreg_nx     = {new_frame[NB-2:0], 1'b0};
                    code_out_nx  = new_frame[NB-1];
                    bit_cnt_nx   = '0;
                    retry_cnt_nx = '0;
                    state_nx     = S_SEND;
                end
            end
            S_SEND: begin
                if (bit_cnt == BIT_LAST) begin
                    gap_cnt_nx = '0;
                    state_nx   = S_WAIT;
                end else begin
                    bit_cnt_nx  = bit_cnt + 1'b1;
                    code_out_nx = shreg[NB-1];
                    shreg_nx    = {shreg[NB-2:0], 1'b0};
                end
            end
            S_WAIT: begin
                if (unlocked_in) begin
                    done_nx  = 1'b1;
                    state_nx = S_DONE;
                end else if (gap_cnt != GAP_LAST) begin
                    gap_cnt_nx = gap_cnt + 1'b1;
                end else if (retry_cnt < RETRY_LIM) begin
                    retry_cnt_nx = retry_cnt + 1'b1;
                    code_out_nx  = old_frame[NB-1];
                    shreg_nx     = {old_frame[NB-2:0], 1'b0};
                    bit_cnt_nx   = '0;
                    state_nx     = S_SEND;
                end else begin
                    fail_nx  = 1'b1;
                    state_nx = S_FAIL;
                end
            end
            S_DONE: state_nx = S_IDLE;
            S_FAIL: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        // abort beats everything, including a same-cycle start
        if (abort) begin
            state_nx     = S_IDLE;
            code_q_nx    = code_q;
            shreg_nx     = '0;
            bit_cnt_nx   = '0;
            gap_cnt_nx   = '0;
            retry_cnt_nx = '0;
            code_out_nx  = 1'b0;
            done_nx      = 1'b0;
            fail_nx      = 1'b0;
        end

        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            code_q    <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            retry_cnt <= '0;
            code_out  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nx;
            code_q    <= code_q_nx;
            shreg     <= shreg_nx;
            bit_cnt   <= bit_cnt_nx;
            gap_cnt   <= gap_cnt_nx;
            retry_cnt <= retry_cnt_nx;
            code_out  <= code_out_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            fail      <= fail_nx;
        end
    end

endmodule

// File: tb/tb_door_code_tx.sv
// tb_door_code_tx: randomized self-checking bench for door_code_tx.
// Expected traces come from a timeline model of attempts, gaps and pulses.
module tb_door_code_tx;

    localparam int CW  = 4;
    localparam int GAP = 3;
    localparam int MR  = 2;
`ifdef PARITY_TX_EN
    localparam int NB = CW + 1;
`else
    localparam int NB = CW;
`endif
    localparam int LEN = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          unlocked_in = 1'b0;
    logic [CW-1:0] code = '0;
    logic          code_out;
    logic          busy;
    logic          done;
    logic          fail;

    int vectors = 0;
    int errors = 0;

    bit         unl[LEN];
    logic [3:0] exp_v[LEN];

    door_code_tx #(
        .CODE_W(CW),
        .GAP_CYCLES(GAP),
        .MAX_RETRY(MR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .code(code),
        .abort(abort),
        .unlocked_in(unlocked_in),
        .code_out(code_out),
        .busy(busy),
        .done(done),
        .fail(fail)
    );

    always #5 clk = ~clk;

    function automatic logic frame_bit(input logic [CW-1:0] c, input int b);
        if (b < CW) return c[CW-1-b];
        return ^c;
    endfunction

    task automatic clear_unl();
        for (int i = 0; i < LEN; i++) unl[i] = 1'b0;
    endtask

    // Expected {code_out,busy,done,fail} per cycle; t=0 is the cycle after the start edge
    task automatic build_model(input logic [CW-1:0] c, output int tend);
        int t;
        bit fin;
        t = 0;
        fin = 1'b0;
        for (int i = 0; i < LEN; i++) exp_v[i] = 4'b0000;
        for (int a = 0; a <= MR && !fin; a++) begin
            for (int b = 0; b < NB; b++) begin
                exp_v[t] = {frame_bit(c, b), 3'b100};
                t++;
            end
            for (int g = 0; g < GAP && !fin; g++) begin
                exp_v[t] = 4'b0100;
                if (unl[t]) begin
                    fin = 1'b1;
                    exp_v[t+1] = 4'b0110;
                end
                t++;
            end
        end
        if (!fin) exp_v[t] = 4'b0101;
        tend = t + 1;
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge of the first idle cycle
    task automatic run_txn(input string name, input logic [CW-1:0] c, input bit inj);
        int tend;
        logic [3:0] got;
        build_model(c, tend);
        start = 1'b1;
        code = c;
        unlocked_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t <= tend; t++) begin
            got = {code_out, busy, done, fail};
            vectors++;
            if (got !== exp_v[t]) begin
                errors++;
                $display("FAIL %s t=%0d got=%b exp=%b", name, t, got, exp_v[t]);
            end
            unlocked_in = (t < tend) ? unl[t] : 1'b0;
            start = 1'b0;
            if (inj && t < tend && exp_v[t][2] && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                code = CW'($urandom);
            end
            if (t < tend) @(negedge clk);
        end
        start = 1'b0;
        unlocked_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            code = CW'($urandom);
            @(negedge clk);
            got = {code_out, busy, done, fail};
            vectors++;
            if (got !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold got=%b exp=0000", got);
            end
        end
        start = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = {code_out, busy, done, fail};
            vectors++;
            if (got !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle got=%b exp=0000", got);
            end
        end
    endtask

    task automatic test_first_try();
        clear_unl();
        unl[NB] = 1'b1;
        run_txn("first_try", 4'b0010, 1'b0);
    endtask

    task automatic test_all_fail();
        clear_unl();
        run_txn("all_fail", 4'b1011, 1'b0);
    endtask

    task automatic test_second_window();
        clear_unl();
        unl[1] = 1'b1;
        unl[2] = 1'b1;
        unl[(NB + GAP) + NB + 1] = 1'b1;
        run_txn("second_window", 4'b1101, 1'b1);
    endtask

    task automatic test_last_wait_cycle();
        clear_unl();
        unl[NB + GAP - 1] = 1'b1;
        run_txn("last_wait", 4'b0111, 1'b0);
    endtask

    task automatic test_random();
        int a;
        for (int i = 0; i < 30; i++) begin
            clear_unl();
            a = $urandom_range(0, MR + 1);
            if (a <= MR) unl[a * (NB + GAP) + NB + $urandom_range(0, GAP - 1)] = 1'b1;
            for (int t = 0; t < LEN; t++)
                if ($urandom_range(0, 9) == 0) unl[t] = 1'b1;
            run_txn("random", CW'($urandom), 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        clear_unl();
        unl[NB + 1] = 1'b1;
        run_txn("b2b_a", 4'b1001, 1'b0);
        clear_unl();
        run_txn("b2b_b", 4'b0110, 1'b0);
    endtask

    task automatic test_abort();
        logic [CW-1:0] c;
        logic [3:0] got;
        logic [3:0] e;
        c = 4'b1010;
        start = 1'b1;
        code = c;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 9; t++) begin
            if (t == 0) e = {c[CW-1], 3'b100};
            else if (t == 1) e = {c[CW-2], 3'b100};
            else e = 4'b0000;
            got = {code_out, busy, done, fail};
            vectors++;
            if (got !== e) begin
                errors++;
                $display("FAIL abort t=%0d got=%b exp=%b", t, got, e);
            end
            abort = (t == 1) || (t == 4);
            start = (t == 4);
            code = ~c;
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [3:0] got;
        start = 1'b1;
        code = 4'b1111;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        got = {code_out, busy, done, fail};
        vectors++;
        if (got !== 4'b1100) begin
            errors++;
            $display("FAIL async_pre got=%b exp=1100", got);
        end
        #2 reset = 1'b0;
        #1;
        got = {code_out, busy, done, fail};
        vectors++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset got=%b exp=0000", got);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        got = {code_out, busy, done, fail};
        vectors++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL async_release got=%b exp=0000", got);
        end
    endtask

    initial begin
        test_reset();
        test_first_try();
        test_all_fail();
        test_second_window();
        test_last_wait_cycle();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
